// File: rtl/alu_result_buffer_if.sv
// Handshake/data bundle between the ALU, the result buffer and its consumer.
// Purely wiring; carries no state and adds no latency.
// Backpressure is carried by in_ready (producer side) and out_ready (consumer side).
interface alu_result_buffer_if #(
  parameter int DATA_W = 32
);
  // producer side
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] Result;
  logic              Carry;
  logic              OverFlow;
  logic              Zero;
  logic              Negative;
  logic [3:0]        ALUControl;
  // consumer side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [3:0]        out_flags;
  logic [3:0]        out_op;

  // the buffer itself
  modport slave (
    input  in_valid, Result, Carry, OverFlow, Zero, Negative, ALUControl, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_op
  );

  // whoever drives the buffer (ALU + consumer, or a bench)
  modport master (
    output in_valid, Result, Carry, OverFlow, Zero, Negative, ALUControl, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_op
  );
endinterface

// File: rtl/alu_result_buffer.sv
// Small FIFO holding ALU result + flags + opcode, with sticky overflow and push counter.
// Latency: an entry pushed at edge k is presented after edge k (no same-cycle bypass).
// Backpressure: in_ready drops when full, independent of out_ready (no pass-through).
module alu_result_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_result_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     sticky_ovf,
  input  logic                     clr_sticky,
  output logic [CNT_W-1:0]         op_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_result [DEPTH];
  logic [3:0]        mem_flags  [DEPTH];
  logic [3:0]        mem_op     [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Handshakes come from registered occupancy only.
  assign bus.in_ready  = (level != LVL_W'(DEPTH));
  assign bus.out_valid = (level != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Storage write: data is sampled as-is, flags packed {N, Z, C, V}; no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= bus.Result;
      mem_flags[wr_ptr]  <= {bus.Negative, bus.Zero, bus.Carry, bus.OverFlow};
      mem_op[wr_ptr]     <= bus.ALUControl;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Status: overflow set beats a simultaneous clear; counter counts pushes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      op_cnt     <= '0;
    end else begin
      if (push && bus.OverFlow) sticky_ovf <= 1'b1;
      else if (clr_sticky)      sticky_ovf <= 1'b0;
      if (push) op_cnt <= op_cnt + CNT_W'(1);
    end
  end

  // Head presentation, zeroed whenever nothing is valid.
  always_comb begin
    bus.out_result = '0;
    bus.out_flags  = '0;
    bus.out_op     = '0;
    if (bus.out_valid) begin
      bus.out_result = mem_result[rd_ptr];
      bus.out_flags  = mem_flags[rd_ptr];
      bus.out_op     = mem_op[rd_ptr];
    end
  end
endmodule
